shifter_lfsr_galois_stream: RTL and testbench
=============================================

Name: shifter_lfsr_galois_stream

Overview:
Parametrised Galois LFSR generator with a valid/ready output stream.
- Advances STEPS shifts per accepted beat.
- Taps are a runtime polynomial mask, not an index list.
- Detects wrap-around and measures the sequence period in beats.
- Detects and handles the all-zero lockup state.
- Used as the pseudo-random source for BIST pattern generation, scramblers and test traffic generators in the common library.

Parameters:
WIDTH, 16, LFSR state width (3..64)
STEPS, 1, Galois shifts applied per accepted beat (1..WIDTH)
CNT_WIDTH, 32, width of the beat/period counter

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_enable  input  1  run request; low drains the current beat, then idles
i_seed_load  input  1  load i_seed_data as state and as wrap reference
i_seed_data  input  WIDTH  seed value
i_taps  input  WIDTH  polynomial mask; bit k=1 XORs feedback into bit k; bit 0 forced to 1 internally
o_valid  output  1  o_data holds a beat
i_ready  input  1  consumer accepts the beat
o_data  output  WIDTH  current LFSR state
o_wrap  output  1  one-cycle pulse: the accepted beat returned state to the reference
o_period  output  CNT_WIDTH  beats between reference and return, latched at wrap
o_period_valid  output  1  o_period is meaningful; sticky until next seed load or reset
o_lockup  output  1  state is all-zero

Behaviour:
- One step: fb = s[WIDTH-1]; s' = {s[WIDTH-2:0],1'b0} ^ ({WIDTH{fb}} & (i_taps | 1)). An advance applies STEPS steps combinationally within one cycle.
- Reset values:
  - state and reference = all ones; FSM = IDLE.
  - o_valid, o_wrap, o_period_valid, o_lockup = 0.
  - o_period and beat counter = 0.
- FSM states IDLE, RUN, LOCK:
  - IDLE: i_enable=1 -> RUN; o_valid rises on the next cycle with o_data = state.
  - RUN: o_valid=1. Accept (o_valid&i_ready) -> state advances STEPS, counter +1; the new o_data is visible the following cycle with no bubble.
  - RUN, hold: o_valid&!i_ready -> o_data held stable, no advance.
  - RUN, drain: i_enable=0 -> stay in RUN until the pending beat is accepted, then IDLE with o_valid=0.
- Seed load has top priority below reset, in any state:
  - state = reference = i_seed_data; counter = 0; o_period_valid = 0; o_valid = 0 for that cycle.
  - Next state: RUN if i_enable, else IDLE.
  - If the seed is zero -> LOCK.
- Wrap: on accept, if the post-advance state == reference:
  - o_wrap pulses one cycle; o_period = counter+1; o_period_valid = 1; counter = 0.
  - With STEPS>1 the reference is compared only at beat boundaries.
- Counter saturates at all ones; it never wraps.
- LOCK: o_valid=0, o_lockup=1. Only a nonzero seed load leaves LOCK (-> RUN/IDLE as above). i_enable is ignored.
- Simultaneous seed load and accept: the seed wins; the accepted beat is consumed and no wrap is reported.
- Tap changes take effect on the next advance. Software must keep taps static during a period measurement.
- Reset mid-stream: all state returns to reset values on the next edge, with no partial beat.

Optional Feature:
LFSR_LOCKUP_RECOVER_EN.
- Defined: entering zero state skips LOCK. State and reference reload to all ones, counter clears, o_lockup pulses one cycle, and the FSM continues in RUN/IDLE per i_enable.
- Undefined: LOCK behaviour as above, with o_lockup level-high.

Decomposition:
- Package shifter_lfsr_pkg: FSM state enum (IDLE/RUN/LOCK) and function lfsr_galois_step(state, taps) for a single step.
- Sub-module shifter_lfsr_galois_step_n: combinational STEPS-unrolled next-state from state and taps, reusable by the checker model.
- FSM, handshake, counter and wrap logic live in the top module.

Test Plan:
- WIDTH=8, STEPS=1, taps=8'h1D, seed 8'h01 loaded, enable, i_ready=1 -> o_data sequence 01,02,04,08,10,20,40,80,1D,3A.
- Same config, run 255 accepts -> o_wrap on beat 255, o_period=255, o_period_valid=1; the next beat is 8'h02.
- Random i_ready toggling (50%) -> o_data never changes while o_valid&!i_ready; the accepted sequence is identical to the i_ready=1 run.
- STEPS=4, taps=8'h1D, seed 8'h01 -> o_data 01,10,1D,... i.e. every 4th state of the STEPS=1 sequence. Wrap at beat 255 is expected because gcd(4,255)=1.
- Seed load 8'h00 -> o_lockup=1, o_valid=0, enable ignored; seed 8'h55 -> o_lockup=0 and o_data=55. With LFSR_LOCKUP_RECOVER_EN: a one-cycle o_lockup pulse, then o_data=FF.
- i_rst asserted mid-run with o_valid high and a stalled beat -> next cycle o_valid=0 and state=FF; the first beat after enable is FF.

Source files
------------

// File: rtl/shifter_lfsr_galois_stream_pkg.sv
// Shared types and the single-step Galois LFSR function for the shifter_lfsr_galois_stream slice.
package shifter_lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } lfsr_state_e;

    localparam int LFSR_MAX_WIDTH = 64;

    // One Galois shift on a WIDTH-bit state carried in a 64-bit container; bits above width stay zero.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_galois_step(
        input logic [LFSR_MAX_WIDTH-1:0] state,
        input logic [LFSR_MAX_WIDTH-1:0] taps,
        input int                        width
    );
        logic [LFSR_MAX_WIDTH-1:0] mask;
        logic [LFSR_MAX_WIDTH-1:0] shifted;
        logic [5:0]                msb;
        logic                      fb;
        mask    = (width >= LFSR_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        msb     = 6'(width - 1);
        fb      = state[msb];
        shifted = (state << 1) ^ ({LFSR_MAX_WIDTH{fb}} & (taps | 64'd1));
        return shifted & mask;
    endfunction

endpackage

// File: rtl/shifter_lfsr_galois_stream_if.sv
// Valid/ready output stream carrying the LFSR state from generator (master) to consumer (slave).
interface shifter_lfsr_galois_stream_if #(
    parameter int WIDTH = 16
);
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;

    modport master (output o_valid, output o_data, input i_ready);
    modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/shifter_lfsr_galois_step_n.sv
// Combinational STEPS-deep unrolled Galois LFSR advance; purely a function of state and taps.
module shifter_lfsr_galois_step_n
    import shifter_lfsr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEPS = 1
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next_state
);

    logic [LFSR_MAX_WIDTH-1:0] acc;

    always_comb begin
        acc = LFSR_MAX_WIDTH'(state);
        for (int i = 0; i < STEPS; i++) begin
            acc = lfsr_galois_step(acc, LFSR_MAX_WIDTH'(taps), WIDTH);
        end
        next_state = acc[WIDTH-1:0];
    end

endmodule

// File: rtl/shifter_lfsr_galois_stream.sv
// Galois LFSR stream generator with wrap/period measurement and zero-state lockup handling.
// Optional macro LFSR_LOCKUP_RECOVER_EN: a zero seed reloads all ones instead of parking in LOCK.
module shifter_lfsr_galois_stream
    import shifter_lfsr_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STEPS     = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic                          i_seed_load,
    input  logic [WIDTH-1:0]              i_seed_data,
    input  logic [WIDTH-1:0]              i_taps,
    shifter_lfsr_galois_stream_if.master  bus,
    output logic                          o_wrap,
    output logic [CNT_WIDTH-1:0]          o_period,
    output logic                          o_period_valid,
    output logic                          o_lockup
);

    lfsr_state_e          fsm_q, fsm_d;
    logic [WIDTH-1:0]     lfsr_q, lfsr_d, ref_q, ref_d, lfsr_adv;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
    logic                 valid_q, valid_d, wrap_q, wrap_d, pvalid_q, pvalid_d;
    logic                 accept;
    logic                 lockup_pulse_d;

    shifter_lfsr_galois_step_n #(
        .WIDTH (WIDTH),
        .STEPS (STEPS)
    ) u_step_n (
        .state      (lfsr_q),
        .taps       (i_taps),
        .next_state (lfsr_adv)
    );

    assign accept  = valid_q & bus.i_ready;
    // Saturate rather than wrap so an over-long period never reads as a short one.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        fsm_d          = fsm_q;
        lfsr_d         = lfsr_q;
        ref_d          = ref_q;
        cnt_d          = cnt_q;
        valid_d        = valid_q;
        wrap_d         = 1'b0;
        period_d       = period_q;
        pvalid_d       = pvalid_q;
        lockup_pulse_d = 1'b0;

        if (i_seed_load) begin
            cnt_d    = '0;
            pvalid_d = 1'b0;
            valid_d  = 1'b0;
            if (i_seed_data == '0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                lfsr_d         = '1;
                ref_d          = '1;
                lockup_pulse_d = 1'b1;
                fsm_d          = i_enable ? ST_RUN : ST_IDLE;
`else
                lfsr_d = '0;
                ref_d  = '0;
                fsm_d  = ST_LOCK;
`endif
            end else begin
                lfsr_d = i_seed_data;
                ref_d  = i_seed_data;
                fsm_d  = i_enable ? ST_RUN : ST_IDLE;
            end
        end else begin
            unique case (fsm_q)
                ST_IDLE: begin
                    valid_d = 1'b0;
                    if (i_enable) begin
                        fsm_d   = ST_RUN;
                        valid_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        lfsr_d = lfsr_adv;
                        if (lfsr_adv == ref_q) begin
                            wrap_d   = 1'b1;
                            period_d = cnt_inc;
                            pvalid_d = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    // Drain: leave only once nothing is pending on the bus.
                    if (!i_enable && (accept || !valid_q)) begin
                        fsm_d   = ST_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
                ST_LOCK: valid_d = 1'b0;
                default: begin
                    fsm_d   = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q    <= ST_IDLE;
            lfsr_q   <= '1;
            ref_q    <= '1;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            fsm_q    <= fsm_d;
            lfsr_q   <= lfsr_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
        end
    end

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic lockup_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) lockup_q <= 1'b0;
        else       lockup_q <= lockup_pulse_d;
    end
    assign o_lockup = lockup_q;
`else
    logic unused_lockup_pulse;
    assign unused_lockup_pulse = lockup_pulse_d;
    assign o_lockup            = (fsm_q == ST_LOCK);
`endif

    assign bus.o_valid    = valid_q;
    assign bus.o_data     = lfsr_q;
    assign o_wrap         = wrap_q;
    assign o_period       = period_q;
    assign o_period_valid = pvalid_q;

endmodule

// File: tb/tb_shifter_lfsr_galois_stream.sv
// Directed bench for shifter_lfsr_galois_stream: 8-bit LFSR, taps 8'h1D, STEPS=1/4 and a narrow counter.
module tb_shifter_lfsr_galois_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, enable, seed_load, ready;
    logic [W-1:0] seed, taps;

    always #5 clk = ~clk;

    shifter_lfsr_galois_stream_if #(.WIDTH(W)) bus1 (), bus4 (), bus_s ();
    assign bus1.i_ready  = ready;
    assign bus4.i_ready  = ready;
    assign bus_s.i_ready = ready;

    logic        wrap1, pvalid1, lock1, wrap4, pvalid4, lock4, wrap_s, pvalid_s, lock_s;
    logic [31:0] period1, period4;
    logic [3:0]  period_s;

    shifter_lfsr_galois_stream #(.WIDTH(W), .STEPS(1), .CNT_WIDTH(32)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
        .i_seed_data(seed), .i_taps(taps), .bus(bus1), .o_wrap(wrap1),
        .o_period(period1), .o_period_valid(pvalid1), .o_lockup(lock1));

    shifter_lfsr_galois_stream #(.WIDTH(W), .STEPS(4), .CNT_WIDTH(32)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
        .i_seed_data(seed), .i_taps(taps), .bus(bus4), .o_wrap(wrap4),
        .o_period(period4), .o_period_valid(pvalid4), .o_lockup(lock4));

    shifter_lfsr_galois_stream #(.WIDTH(W), .STEPS(1), .CNT_WIDTH(4)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
        .i_seed_data(seed), .i_taps(taps), .bus(bus_s), .o_wrap(wrap_s),
        .o_period(period_s), .o_period_valid(pvalid_s), .o_lockup(lock_s));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] value);
        seed      = value;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    function automatic logic [W-1:0] m_step(input logic [W-1:0] s, input logic [W-1:0] t);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? (t | 8'h01) : 8'h00);
    endfunction

    typedef struct {
        logic         ready;
        logic [W-1:0] d1;
        logic [W-1:0] d4;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] exp1, exp4;
        int           n;
        logic         found;

        vecs[0]  = '{1'b1, 8'h01, 8'h01};
        vecs[1]  = '{1'b1, 8'h02, 8'h10};
        vecs[2]  = '{1'b0, 8'h04, 8'h1D};
        vecs[3]  = '{1'b0, 8'h04, 8'h1D};
        vecs[4]  = '{1'b1, 8'h04, 8'h1D};
        vecs[5]  = '{1'b1, 8'h08, 8'hCD};
        vecs[6]  = '{1'b1, 8'h10, 8'h4C};
        vecs[7]  = '{1'b1, 8'h20, 8'hB4};
        vecs[8]  = '{1'b1, 8'h40, 8'h8F};
        vecs[9]  = '{1'b1, 8'h80, 8'h18};
        vecs[10] = '{1'b1, 8'h1D, 8'h9D};
        vecs[11] = '{1'b1, 8'h3A, 8'h25};

        rst = 1'b1; enable = 1'b0; seed_load = 1'b0; ready = 1'b0; seed = '0; taps = 8'h1D;
        tick();
        tick();
        check("rst_valid",   64'(bus1.o_valid), 64'd0);
        check("rst_data",    64'(bus1.o_data),  64'hFF);
        check("rst_wrap",    64'(wrap1),        64'd0);
        check("rst_pvalid",  64'(pvalid1),      64'd0);
        check("rst_period",  64'(period1),      64'd0);
        check("rst_lockup",  64'(lock1),        64'd0);
        rst = 1'b0;

        // Seed load: the load edge leaves a one-cycle bubble, then the seed is offered.
        enable = 1'b1; ready = 1'b1;
        load(8'h01);
        check("load_bubble", 64'(bus1.o_valid), 64'd0);
        check("load_data",   64'(bus1.o_data),  64'h01);
        tick();

        for (int i = 0; i < 12; i++) begin
            ready = vecs[i].ready;
            check($sformatf("vec%0d_valid", i), 64'(bus1.o_valid), 64'd1);
            check($sformatf("vec%0d_data1", i), 64'(bus1.o_data),  64'(vecs[i].d1));
            check($sformatf("vec%0d_data4", i), 64'(bus4.o_data),  64'(vecs[i].d4));
            check($sformatf("vec%0d_wrap", i),  64'(wrap1),        64'd0);
            tick();
        end

        // Drain: enable drops with a stalled beat pending.
        ready = 1'b0; enable = 1'b0;
        tick();
        check("drain_hold_valid", 64'(bus1.o_valid), 64'd1);
        check("drain_hold_data",  64'(bus1.o_data),  64'h74);
        ready = 1'b1;
        tick();
        check("drain_idle_valid", 64'(bus1.o_valid), 64'd0);
        check("drain_idle_data",  64'(bus1.o_data),  64'hE8);
        tick();
        check("idle_stays",       64'(bus1.o_valid), 64'd0);
        enable = 1'b1;
        tick();
        check("rerun_valid",      64'(bus1.o_valid), 64'd1);
        check("rerun_data",       64'(bus1.o_data),  64'hE8);

        // Full period: wrap must appear on accepted beat 255 and nowhere earlier.
        load(8'h01);
        check("wrap_pvalid_clr", 64'(pvalid1), 64'd0);
        tick();
        n = 0; found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            n++;
            if (wrap1 === 1'b1) found = 1'b1;
        end
        check("wrap_seen",     64'(found),        64'd1);
        check("wrap_beat",     64'(n),            64'd255);
        check("wrap_period",   64'(period1),      64'd255);
        check("wrap_pvalid",   64'(pvalid1),      64'd1);
        check("wrap_data",     64'(bus1.o_data),  64'h01);
        check("wrap4_pulse",   64'(wrap4),        64'd1);
        check("wrap4_period",  64'(period4),      64'd255);
        check("sat_period",    64'(period_s),     64'hF);
        tick();
        check("post_wrap_data",   64'(bus1.o_data), 64'h02);
        check("post_wrap_pulse",  64'(wrap1),       64'd0);
        check("post_wrap_pvalid", 64'(pvalid1),     64'd1);

        // Random back-pressure: held data while stalled, same accepted sequence as free-running.
        load(8'h01);
        tick();
        exp1 = 8'h01; exp4 = 8'h01;
        for (int i = 0; i < 120; i++) begin
            ready = 1'($urandom_range(0, 1));
            check("rnd_valid", 64'(bus1.o_valid), 64'd1);
            check("rnd_data1", 64'(bus1.o_data),  64'(exp1));
            check("rnd_data4", 64'(bus4.o_data),  64'(exp4));
            if (ready) begin
                exp1 = m_step(exp1, taps);
                for (int k = 0; k < 4; k++) exp4 = m_step(exp4, taps);
            end
            tick();
        end

        // Seed load coinciding with the accept that would have wrapped.
        ready = 1'b1;
        load(8'h01);
        tick();
        for (int i = 0; i < 254; i++) tick();
        check("prewrap_data", 64'(bus1.o_data), 64'h8E);
        seed = 8'h55; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("coll_wrap",   64'(wrap1),        64'd0);
        check("coll_data",   64'(bus1.o_data),  64'h55);
        check("coll_valid",  64'(bus1.o_valid), 64'd0);
        check("coll_pvalid", 64'(pvalid1),      64'd0);
        tick();
        check("coll_next_valid", 64'(bus1.o_valid), 64'd1);
        check("coll_next_data",  64'(bus1.o_data),  64'h55);

        // Zero seed.
        load(8'h00);
        check("zero_lockup", 64'(lock1),        64'd1);
        check("zero_valid",  64'(bus1.o_valid), 64'd0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("zero_reload_data", 64'(bus1.o_data), 64'hFF);
        tick();
        check("zero_pulse_end",   64'(lock1),        64'd0);
        check("zero_resume",      64'(bus1.o_valid), 64'd1);
        check("zero_resume_data", 64'(bus1.o_data),  64'hFF);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_valid", 64'(bus1.o_valid), 64'd0);
            check("lock_level", 64'(lock1),        64'd1);
        end
        load(8'h55);
        check("unlock_lockup", 64'(lock1),       64'd0);
        check("unlock_data",   64'(bus1.o_data), 64'h55);
        tick();
        check("unlock_valid",  64'(bus1.o_valid), 64'd1);
        check("unlock_data2",  64'(bus1.o_data),  64'h55);
`endif

        // Reset with a stalled beat on the bus.
        ready = 1'b0;
        tick();
        check("stall_valid", 64'(bus1.o_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid",  64'(bus1.o_valid), 64'd0);
        check("mid_rst_data",   64'(bus1.o_data),  64'hFF);
        check("mid_rst_period", 64'(period1),      64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_valid", 64'(bus1.o_valid), 64'd1);
        check("post_rst_data",  64'(bus1.o_data),  64'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
